// File: rtl/phy_pkg.sv
// phy_pkg: shared types and constants for the PHY pattern generator.
// FSM state encoding, payload mode codes and default symbols.
package phy_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    COM  = 3'd2,
    PAY  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] MODE_TABLE = 2'd0;
  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_COM   = 2'd3;

  localparam logic [7:0]  COM_SYMBOL  = 8'hBC;
  localparam logic [31:0] HDR_DEFAULT = 32'hABFD_1234;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phy_lfsr.sv
// phy_lfsr: Galois LFSR with synchronous reload and advance enable.
// Ports: clk_2f, reset (async low), load, adv, q (current state).
module phy_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h0000_0001)
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             load,
  input  logic             adv,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= SEED;
    end else if (adv) begin
      r_q <= r_q[0] ? ((r_q >> 1) ^ POLY)
                    : (r_q >> 1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/phy_pattern_gen.sv
// phy_pattern_gen: framed burst source (header, COM, payload) on valid/ready.
// Ports: clk_2f, reset, start, mode, ready_in -> data_out, valid_out, busy, done.
module phy_pattern_gen
  import phy_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          N_HDR     = 4,
  parameter logic [31:0] HDR_WORD  = HDR_DEFAULT,
  parameter int          N_COM     = 4,
  parameter logic [7:0]  COM_SYM   = COM_SYMBOL,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] PAT0      = 32'hFFFF_FFFF,
  parameter logic [31:0] PAT1      = 32'hEEEE_EEEE,
  parameter logic [31:0] PAT2      = 32'hDDDD_DDDD,
  parameter logic [31:0] PAT3      = 32'hCCCC_CCCC,
  parameter logic [31:0] LFSR_POLY = 32'h8020_0003,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              busy,
  output logic              done
);

  localparam int MAXN = max3(N_HDR, N_COM, BURST_LEN);
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] HDR_LAST = CW'(N_HDR - 1);
  localparam logic [CW-1:0] COM_LAST = CW'(N_COM - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(BURST_LEN - 1);

  localparam logic [DATA_W-1:0] W_HDR  = DATA_W'(HDR_WORD);
  localparam logic [DATA_W-1:0] W_COM  = {(DATA_W/8){COM_SYM}};
  localparam logic [DATA_W-1:0] W_POLY = DATA_W'(LFSR_POLY);
  localparam logic [DATA_W-1:0] W_SEED = DATA_W'(LFSR_SEED);

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [1:0]        r_mode, w_mode_n;
  logic [1:0]        r_idx, w_idx_n;
  logic [DATA_W-1:0] r_data, w_data_n;
  logic              r_valid, w_valid_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;

  logic              w_acc;
  logic              w_enter_pay;
  logic [1:0]        w_pay_mode;
  logic              w_lfsr_load;
  logic              w_lfsr_adv;
  logic [DATA_W-1:0] w_lfsr_q;

  function automatic logic [DATA_W-1:0] pat_word(
    input logic [1:0] idx
  );
    logic [DATA_W-1:0] w;
    unique case (idx)
      2'd0:    w = DATA_W'(PAT0);
      2'd1:    w = DATA_W'(PAT1);
      2'd2:    w = DATA_W'(PAT2);
      default: w = DATA_W'(PAT3);
    endcase
    return w;
  endfunction

  // The LFSR runs one step ahead of data_out: on each payload
  // word the current q is registered out and q advances.
  phy_lfsr #(
    .WIDTH (DATA_W),
    .POLY  (W_POLY),
    .SEED  (W_SEED)
  ) u_lfsr (
    .clk_2f (clk_2f),
    .reset  (reset),
    .load   (w_lfsr_load),
    .adv    (w_lfsr_adv),
    .q      (w_lfsr_q)
  );

  assign w_acc = r_valid & ready_in;
  assign w_pay_mode = (r_state == IDLE) ? mode : r_mode;

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_mode_n    = r_mode;
    w_idx_n     = r_idx;
    w_data_n    = r_data;
    w_valid_n   = r_valid;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_enter_pay = 1'b0;
    w_lfsr_load = 1'b0;
    w_lfsr_adv  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_mode_n  = mode;
          w_cnt_n   = '0;
          w_valid_n = 1'b1;
          w_busy_n  = 1'b1;
          if (N_HDR != 0) begin
            w_state_n = HDR;
            w_data_n  = W_HDR;
          end else if (N_COM != 0) begin
            w_state_n = COM;
            w_data_n  = W_COM;
          end else begin
            w_state_n   = PAY;
            w_enter_pay = 1'b1;
          end
        end
      end
      HDR: begin
        if (w_acc) begin
          if (r_cnt == HDR_LAST) begin
            w_cnt_n = '0;
            if (N_COM != 0) begin
              w_state_n = COM;
              w_data_n  = W_COM;
            end else begin
              w_state_n   = PAY;
              w_enter_pay = 1'b1;
            end
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      COM: begin
        if (w_acc) begin
          if (r_cnt == COM_LAST) begin
            w_cnt_n     = '0;
            w_state_n   = PAY;
            w_enter_pay = 1'b1;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      PAY: begin
        if (w_acc) begin
          if (r_cnt == PAY_LAST) begin
            w_cnt_n   = '0;
            w_state_n = DONE;
            w_data_n  = '0;
            w_valid_n = 1'b0;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
            unique case (r_mode)
              MODE_TABLE: begin
                w_idx_n  = r_idx + 2'd1;
                w_data_n = pat_word(r_idx + 2'd1);
              end
              MODE_INC: begin
                w_data_n = r_data + DATA_W'(1);
              end
              MODE_LFSR: begin
                w_data_n   = w_lfsr_q;
                w_lfsr_adv = 1'b1;
              end
              default: begin
                w_data_n = W_COM;
              end
            endcase
          end
        end
      end
      DONE: begin
        w_state_n   = IDLE;
        w_lfsr_load = 1'b1;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    // First payload word; generators restart for every burst.
    if (w_enter_pay) begin
      w_idx_n = 2'd0;
      unique case (w_pay_mode)
        MODE_TABLE: w_data_n = pat_word(2'd0);
        MODE_INC:   w_data_n = '0;
        MODE_LFSR: begin
          w_data_n   = w_lfsr_q;
          w_lfsr_adv = 1'b1;
        end
        default:    w_data_n = W_COM;
      endcase
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= 2'd0;
      r_idx   <= 2'd0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_mode  <= w_mode_n;
      r_idx   <= w_idx_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
